// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output req, we, a, wd, input rd, ready, busy, err);
  modport slave  (input req, we, a, wd, output rd, ready, busy, err);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and a one-cycle ready pulse.
// Optional macro MEM_ERR_EN enables misaligned/out-of-range access faults.
module mem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           we_q, fault_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wd_q;
  logic           ready_q, busy_q, err_q;
  logic [31:0]    rd_q;
  logic [31:0]    mem [DEPTH];

  logic           accept_c, enter_resp_c, fault_c, mem_we_c;
  logic           acc_we_c, acc_fault_c;
  logic [AW-1:0]  acc_idx_c;
  logic [31:0]    acc_wd_c;
  logic           ready_nxt, busy_nxt, err_nxt;
  logic [31:0]    rd_nxt;

`ifdef MEM_ERR_EN
  assign fault_c = (bus.a[1:0] != 2'b00) || (bus.a[31:AW+2] != '0);
`else
  logic unused_a;
  assign fault_c  = 1'b0;
  assign unused_a = ^{bus.a[31:AW+2], bus.a[1:0]};
`endif

  // State register, request capture and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
      rd_q    <= rd_nxt;
      if (accept_c) begin
        we_q    <= bus.we;
        fault_q <= fault_c;
        idx_q   <= bus.a[AW+1:2];
        wd_q    <= bus.wd;
      end
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (WAIT > 0) begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(WAIT - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With WAIT = 0 the acceptance edge is also the commit edge, so use live inputs then
  always_comb begin
    accept_c     = (state == IDLE) && bus.req;
    enter_resp_c = (state_nxt == RESP) && (state != RESP);
    acc_we_c     = accept_c ? bus.we         : we_q;
    acc_fault_c  = accept_c ? fault_c        : fault_q;
    acc_idx_c    = accept_c ? bus.a[AW+1:2]  : idx_q;
    acc_wd_c     = accept_c ? bus.wd         : wd_q;
    mem_we_c     = reset && enter_resp_c && acc_we_c && !acc_fault_c;
    ready_nxt    = (state_nxt == RESP);
    busy_nxt     = (state_nxt == BUSY) || (state_nxt == RESP);
    err_nxt      = enter_resp_c && acc_fault_c;
    rd_nxt       = '0;
    if (enter_resp_c && !acc_we_c && !acc_fault_c) rd_nxt = mem[acc_idx_c];
  end

  // Array has no reset; contents persist across reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[acc_idx_c] <= acc_wd_c;
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.rd    = rd_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT=2 and one with WAIT=0.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  mem_responder_if bus2();
  mem_responder_if bus0();

  mem_responder #(.DEPTH(64), .WAIT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready pulse pops one expected response
  task automatic mon(input bit d0, input logic rdy, input logic [31:0] r, input logic e);
    exp_t x;
    string p;
    p = d0 ? "w0" : "w2";
    if (rdy === 1'b1) begin
      if ((d0 && q0.size() == 0) || (!d0 && q2.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_ready: got ready=1 expected no response (cycle %0d)", p, cyc);
      end else begin
        x = d0 ? q0.pop_front() : q2.pop_front();
        chk({p, "_ready_cycle"}, 32'(cyc), 32'(x.cyc));
        chk({p, "_err"}, {31'd0, e}, {31'd0, x.err});
        if (x.chk_rd) chk({p, "_rd"}, r, x.rd);
      end
    end else begin
      chk({p, "_idle_rd_err"}, {r[30:0] | {30'd0, e}, r[31]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, bus2.ready, bus2.rd, bus2.err);
    mon(1'b1, bus0.ready, bus0.rd, bus0.err);
  end

  task automatic drive(input bit d0, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] data);
    if (d0) begin
      bus0.req = r; bus0.we = w; bus0.a = addr; bus0.wd = data;
    end else begin
      bus2.req = r; bus2.we = w; bus2.a = addr; bus2.wd = data;
    end
  endtask

  // One access; inputs are scrambled right after acceptance to prove capture
  task automatic do_req(input bit d0, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd,
                        input bit chk_rd, input bit e);
    int   wt;
    exp_t x;
    wt = d0 ? 0 : 2;
    @(posedge clk); #1;
    drive(d0, 1'b1, w, addr, data);
    x.rd = exp_rd; x.chk_rd = chk_rd; x.err = e; x.cyc = cyc + 1 + wt;
    if (d0) q0.push_back(x); else q2.push_back(x);
    @(posedge clk); #1;
    drive(d0, 1'b0, ~w, addr ^ 32'h4, data ^ 32'hC);
    chk(d0 ? "w0_busy_rise" : "w2_busy_rise", {31'd0, d0 ? bus0.busy : bus2.busy}, 32'd1);
    repeat (wt + 1) @(posedge clk);
    #1;
    chk(d0 ? "w0_busy_fall" : "w2_busy_fall", {31'd0, d0 ? bus0.busy : bus2.busy}, 32'd0);
  endtask

  initial begin
    exp_t x;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h1);
    // Reset held with req high: nothing may start
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ready", {31'd0, bus2.ready}, 32'd0);
      chk("rst_busy",  {31'd0, bus2.busy},  32'd0);
      chk("rst_err",   {31'd0, bus2.err},   32'd0);
      chk("rst_rd",    bus2.rd,             32'd0);
      chk("rst_busy0", {31'd0, bus0.busy},  32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;

    // Write then read, WAIT=2
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // Input change after acceptance: post-accept inputs become a=0xC, wd=0x9
    do_req(1'b0, 1'b1, 32'hC, 32'h33, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h8, 32'h5, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h8, 32'h0, 32'h5, 1'b1, 1'b0);
    do_req(1'b0, 1'b0, 32'hC, 32'h0, 32'h33, 1'b1, 1'b0);

    // Reset mid-BUSY discards the pending write
    do_req(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mid_busy_before_rst", {31'd0, bus2.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus2.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, bus2.busy}, 32'd0);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b1, 1'b0);

`ifdef MEM_ERR_EN
    do_req(1'b0, 1'b1, 32'h0, 32'h0BAD0000, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h102, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD0000, 1'b1, 1'b0);
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    do_req(1'b0, 1'b1, 32'h104, 32'h0000CAFE, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 32'h0000CAFE, 1'b1, 1'b0);
    do_req(1'b0, 1'b0, 32'h106, 32'h0, 32'h0000CAFE, 1'b1, 1'b0);
`endif

    // WAIT=0: preload, then req held high across two reads
    do_req(1'b1, 1'b1, 32'h0, 32'h11, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 1'b1, 32'h4, 32'h22, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    x.rd = 32'h11; x.chk_rd = 1'b1; x.err = 1'b0; x.cyc = cyc + 1;
    q0.push_back(x);
    x.rd = 32'h22; x.cyc = cyc + 3;
    q0.push_back(x);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    chk("w2_queue_drained", 32'(q2.size()), 32'd0);
    chk("w0_queue_drained", 32'(q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data/instruction memory that sits on the responder side of the multi-cycle core's memory port. It accepts one read or write request at a time and inserts a programmable number of wait states. It returns a single-cycle `ready` pulse carrying read data. This lets the core's memory-wait states be exercised against realistic latency instead of a zero-latency combinational array.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 2.
- `WAIT`, 2: wait-state cycles between acceptance and response; 0–15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: request strobe; sampled only in IDLE.
- `we`, input, 1: 1 = write, 0 = read; captured with `req`.
- `a`, input, 32: byte address; captured with `req`.
- `wd`, input, 32: write data; captured with `req`.
- `rd`, output, 32: read data; valid only while `ready` = 1.
- `ready`, output, 1: one-cycle response pulse.
- `busy`, output, 1: high in BUSY and RESP.
- `err`, output, 1: access fault flag; valid with `ready`.

## Operation
- FSM states:
  - IDLE: `busy` = 0. If `req` = 1, capture `we`, `a`, `wd` into registers.
    - Next state is BUSY with counter = `WAIT`-1 when `WAIT` > 0.
    - Next state is RESP when `WAIT` = 0.
  - BUSY: counter decrements each cycle; at counter = 0 the next state is RESP.
  - RESP: `ready` = 1 for exactly one cycle; the next state is always IDLE.
    - `req` is ignored in RESP.
- Word index = captured `a[log2(DEPTH)+1:2]`.
- Writes commit to the array on the clock edge that enters RESP.
- Read data is registered on that same edge, so `rd` is stable for the whole RESP cycle.
- Read-after-write: a read accepted after a write's RESP cycle returns the new value.
- Inputs may change freely after the acceptance edge; only captured values are used.
- Array contents are not reset; initial contents are undefined unless preloaded by the bench.
- `rd` = 0 whenever `ready` = 0.

## Timing
- Reset values: state = IDLE, `ready` = 0, `busy` = 0, `err` = 0, `rd` = 0, counter = 0.
- Accept at edge N; `ready` is high during cycle N+`WAIT`+1.
  - `WAIT` = 0: `ready` in the cycle right after acceptance.
- Minimum request spacing is `WAIT`+2 cycles. A `req` held high is re-accepted in the IDLE cycle following RESP.
- `busy` rises the cycle after acceptance and falls the cycle after RESP.
- Reset asserted mid-BUSY: the access is aborted and any pending write is discarded (the array is unchanged).
- Reset asserted during RESP: a write committed on entry to RESP remains in the array.
- `req` during BUSY/RESP is not queued.

## Configuration
- Macro `MEM_ERR_EN`.
- Defined:
  - The access faults if `a[1:0]` ≠ 0 or `a` ≥ 4·`DEPTH`.
  - A faulting access still takes full latency, performs no write, returns `rd` = 0, and asserts `err` = 1 with `ready`.
- Undefined:
  - `err` is tied to 0.
  - `a[1:0]` and the upper address bits are ignored, so the address wraps modulo `DEPTH` words.
  - All accesses complete normally.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with `req` = 1 → `ready`, `busy`, `err` and `rd` all 0; no access starts until `reset` = 1.
- Write then read, `WAIT` = 2:
  - Write `a` = 0x10, `wd` = 0xDEADBEEF → `ready` high exactly 3 cycles after acceptance.
  - Read `a` = 0x10 → `rd` = 0xDEADBEEF with `ready`.
- `WAIT` = 0, `req` held high with reads of 0x0 then 0x4 preloaded 0x11/0x22 → responses 2 cycles apart, `rd` = 0x11 then 0x22.
- Input change after acceptance: accept a write to 0x8 with `wd` = 0x5; change `a`/`wd` to 0xC/0x9 next cycle → word 2 = 0x5 and word 3 is unchanged.
- Reset mid-BUSY during a write of 0x1234 to 0x20 → word 8 retains its prior value; FSM is in IDLE after reset is released.
- Address faults with `DEPTH` = 64:
  - With `MEM_ERR_EN` defined, write to 0x102 → `err` = 1, `rd` = 0, no array change.
  - Without the macro, write to 0x104 → word 1 is written and `err` = 0.
